// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART states and default line timing
package uart_pkg;

    localparam int CLK_FREQ_DEFAULT   = 48000000;
    localparam int BAUD_DEFAULT       = 9600;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } uart_state_t;

    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider with synchronous restart
module uart_baud_tick #(
    parameter int DIV = 312
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A restart suppresses the tick so the first tick lands DIV clocks after it.
    assign o_tick = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8 data bits, 1 stop bit
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int BAUD       = BAUD_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic [7:0] data,
    output logic       flag_valid,
    output logic       flag_busy,
    output logic       flag_frame_err,
    output logic       flag_parity_err
);

    localparam int                DIV     = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int                TICK_W  = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] MID_CNT = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] END_CNT = TICK_W'(OVERSAMPLE - 1);

    uart_state_t       r_state;
    uart_state_t       w_next_state;
    logic [1:0]        r_sync;
    logic              r_rx_prev;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_parity_out;
    logic              w_rx;
    logic              w_tick;
    logic              w_start_edge;
    logic              w_mid_sample;
    logic              w_bit_sample;

    assign w_rx         = r_sync[1];
    assign w_start_edge = (r_state == IDLE) && r_rx_prev && !w_rx;
    assign w_mid_sample = w_tick && (r_tick_cnt == MID_CNT);
    assign w_bit_sample = w_tick && (r_tick_cnt == END_CNT);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_restart(w_start_edge),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_state   <= IDLE;
        end else begin
            r_sync    <= {r_sync[0], in};
            r_rx_prev <= w_rx;
            r_state   <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_start_edge) w_next_state = START;
            START:     if (w_mid_sample) w_next_state = w_rx ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (w_bit_sample && (r_bit_cnt == 3'd7)) w_next_state = PARITY;
            PARITY:    if (w_bit_sample) w_next_state = STOP;
`else
            DATA:      if (w_bit_sample && (r_bit_cnt == 3'd7)) w_next_state = STOP;
`endif
            STOP:      if (w_bit_sample) w_next_state = w_rx ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (w_rx) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if ((r_state == PARITY) && w_bit_sample) begin
            r_par_err <= (^r_shift) ^ w_rx;
        end
    end
`else
    logic r_par_err;
    assign r_par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_out <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_out <= 1'b0;

            // Sample points are counted from the start-bit mid-point, not the edge.
            if (w_start_edge || ((r_state == START) && w_mid_sample) || w_bit_sample) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (r_state == START) begin
                r_bit_cnt <= '0;
            end else if ((r_state == DATA) && w_bit_sample) begin
                r_shift   <= {w_rx, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if ((r_state == STOP) && w_bit_sample) begin
                r_data <= r_shift;
                if (w_rx) begin
                    r_valid      <= 1'b1;
                    r_parity_out <= r_par_err;
                end else begin
                    r_frame_err  <= 1'b1;
                end
            end
        end
    end

    assign data            = r_data;
    assign flag_valid      = r_valid;
    assign flag_busy       = (r_state != IDLE);
    assign flag_frame_err  = r_frame_err;
    assign flag_parity_err = r_parity_out;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
module tb_uart_rx;

    localparam int CLK_FREQ   = 614400;
    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = (CLK_FREQ / (BAUD * OVERSAMPLE)) * OVERSAMPLE;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in;
    logic [7:0] data;
    logic       flag_valid;
    logic       flag_busy;
    logic       flag_frame_err;
    logic       flag_parity_err;

    exp_t q[$];
    int   n_checks;
    int   n_fail;
    int   n_ferr_seen;
    int   n_ferr_exp;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in             (in),
        .data           (data),
        .flag_valid     (flag_valid),
        .flag_busy      (flag_busy),
        .flag_frame_err (flag_frame_err),
        .flag_parity_err(flag_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int nbits);
        in = v;
        repeat (nbits * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits,
                              input logic bad_par);
        drive_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ bad_par, 1);
`else
        if (bad_par) $display("note: parity disabled, bad_par ignored");
`endif
        drive_bit(stop_val, stop_bits);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic p);
        exp_t e;
        e.d = d;
        e.p = p;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (flag_frame_err) n_ferr_seen++;
        if (flag_valid || flag_frame_err)
            check("valid_ferr_exclusive", {31'd0, flag_valid & flag_frame_err}, 32'd0);
        if (flag_parity_err && !flag_valid)
            check("perr_without_valid", 32'd1, 32'd0);
        if (flag_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", {24'd0, data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_data", {24'd0, data}, {24'd0, e.d});
                check("sb_parity_err", {31'd0, flag_parity_err}, {31'd0, e.p});
            end
        end
    end

    initial begin
        int busy_cnt;
        n_checks    = 0;
        n_fail      = 0;
        n_ferr_seen = 0;
        n_ferr_exp  = 0;
        rst_n       = 1'b0;
        in          = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_busy", {31'd0, flag_busy}, 32'd0);
        check("reset_valid", {31'd0, flag_valid}, 32'd0);
        check("reset_ferr", {31'd0, flag_frame_err}, 32'd0);
        check("reset_perr", {31'd0, flag_parity_err}, 32'd0);
        rst_n = 1'b1;
        drive_bit(1'b1, 2);

        expect_byte(8'h55, 1'b0);
        send_frame(8'h55, 1'b1, 1, 1'b0);
        check("busy_after_55", {31'd0, flag_busy}, 32'd0);
        check("data_55", {24'd0, data}, 32'h55);
        drive_bit(1'b1, 1);

        expect_byte(8'hA5, 1'b0);
        expect_byte(8'h3C, 1'b0);
        send_frame(8'hA5, 1'b1, 1, 1'b0);
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        check("data_3c", {24'd0, data}, 32'h3C);
        drive_bit(1'b1, 1);

        in = 1'b0;
        repeat (10) @(negedge clk);
        in = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 2 * BIT_CLKS; i++) begin
            @(negedge clk);
            if (flag_busy) busy_cnt++;
        end
        check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
        check("glitch_busy_short", {31'd0, busy_cnt < BIT_CLKS}, 32'd1);
        check("glitch_idle", {31'd0, flag_busy}, 32'd0);
        check("glitch_data_held", {24'd0, data}, 32'h3C);

        n_ferr_exp++;
        send_frame(8'h0F, 1'b0, 3, 1'b0);
        check("wait_high_busy", {31'd0, flag_busy}, 32'd1);
        drive_bit(1'b1, 1);
        check("after_ferr_idle", {31'd0, flag_busy}, 32'd0);
        check("ferr_count", n_ferr_seen, n_ferr_exp);

        fork
            send_frame(8'hFF, 1'b1, 1, 1'b0);
            begin
                repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                check("midframe_reset_busy", {31'd0, flag_busy}, 32'd0);
                check("midframe_reset_data", {24'd0, data}, 32'h00);
                rst_n = 1'b1;
            end
        join
        drive_bit(1'b1, 2);
        check("no_byte_after_reset", {31'd0, flag_busy}, 32'd0);

        expect_byte(8'h81, 1'b0);
        send_frame(8'h81, 1'b1, 1, 1'b0);
        check("data_81", {24'd0, data}, 32'h81);
        drive_bit(1'b1, 1);

`ifdef UART_RX_PARITY_EN
        expect_byte(8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1, 1'b1);
        check("data_07", {24'd0, data}, 32'h07);
        drive_bit(1'b1, 1);
`endif

        drive_bit(1'b1, 2);
        check("sb_empty", q.size(), 32'd0);
        check("ferr_total", n_ferr_seen, n_ferr_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 48000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit (integer, even, >= 8).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in  input  1  serial line, idle high, asynchronous to clk.
REQ-007 data  output  8  last received byte, LSB received first.
REQ-008 flag_valid  output  1  one-cycle pulse: data holds a good byte.
REQ-009 flag_busy  output  1  high from start-bit detection until the frame ends.
REQ-010 flag_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 flag_parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-012 in shall pass through a 2-flop synchronizer before any use; the synchronizer shall reset to 1.
REQ-013 A tick divider shall produce a one-clk tick every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks, truncated (312 at defaults); the divider shall restart at 0 on start-bit detection.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 IDLE: on a synchronized high-to-low transition go to START; flag_busy rises the same cycle.
REQ-016 START: at tick OVERSAMPLE/2 sample the line; low -> DATA, high -> IDLE (false start, no flags pulsed).
REQ-017 DATA: sample every OVERSAMPLE ticks after the start mid-point; bit n goes to shift position n; after bit 7 go to PARITY if enabled, else STOP.
REQ-018 STOP: sample at mid-bit; high -> load data, pulse flag_valid next cycle, go to IDLE; low -> load data, pulse flag_frame_err, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until the synchronized line is high, then IDLE; no start detection in this state.
REQ-020 flag_busy shall fall in the cycle the FSM enters IDLE.
REQ-021 A new start edge arriving during the second half of the stop bit shall be detected (back-to-back frames with no idle gap).
REQ-022 data shall change only when a frame completes; it holds its value otherwise.
REQ-023 flag_valid and flag_frame_err shall never be high together.

Reset
REQ-024 While rst_n is low: FSM = IDLE, data = 8'h00, all flags = 0, counters = 0.
REQ-025 Reset asserted mid-frame shall abort the frame with no flag pulse; after release, reception resumes only on a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN: when defined, one even-parity bit follows the data bits (PARITY state, sampled at mid-bit).
REQ-027 With the macro defined, a parity mismatch shall pulse flag_parity_err in the same cycle as flag_valid; data is still loaded.
REQ-028 Without the macro, the PARITY state shall be absent and flag_parity_err shall be tied to 0.

Structure
REQ-029 Package uart_pkg shall hold the state enumeration, the CLK_FREQ and BAUD defaults, and OVERSAMPLE; the transmitter shares it.
REQ-030 Sub-module uart_baud_tick (parameterized divider with restart input) shall generate the tick.

Verification
REQ-031 Send 0x55 at 9600 baud, 8N1 -> data = 8'h55, one flag_valid pulse, flag_busy low within one bit time after the stop bit.
REQ-032 Send 0xA5 then 0x3C back-to-back with no idle gap -> two flag_valid pulses, data 8'hA5 then 8'h3C.
REQ-033 Drive a 2 µs low glitch on an idle line -> no flags pulsed, FSM back in IDLE, flag_busy pulse shorter than one bit time.
REQ-034 Send 0x0F with the stop bit held low for 3 bit times -> flag_frame_err pulsed once, no flag_valid, no new start until the line is high.
REQ-035 Assert rst_n low during bit 4 of 0xFF, release, then send 0x81 -> only 0x81 reported, data = 8'h81.
REQ-036 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> flag_valid and flag_parity_err pulse together, data = 8'h07.
